// File: rtl/io_out_fifo.sv
`default_nettype none
// ============================================================================
// io_out_fifo : first-word-fall-through output FIFO between the core OUT port
//               and a valid/ready peripheral; writes into a full FIFO are dropped.
//               Optional macro IO_OUT_FIFO_OVFCNT_EN adds a saturating drop counter.
// Revision    : 1.0
// ============================================================================
module io_out_fifo #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      out_en,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic [NUBITS-1:0]         data_out,
    output logic                      m_valid,
    output logic [$clog2(NUIOOU)-1:0] m_addr,
    output logic [NUBITS-1:0]         m_data,
    input  logic                      m_ready,
    output logic [$clog2(FDEPTH):0]   level,
    output logic                      full,
    output logic                      empty,
    output logic                      ovf,
`ifdef IO_OUT_FIFO_OVFCNT_EN
    output logic [7:0]                ovf_cnt,
`endif
    input  logic                      ovf_clr
);

    localparam int C_AW = $clog2(NUIOOU);
    localparam int C_PW = $clog2(FDEPTH);
    localparam int C_LW = C_PW + 1;
    localparam int C_EW = C_AW + NUBITS;
    localparam logic [C_LW-1:0] C_DEPTH = C_LW'(FDEPTH);

    logic [C_EW-1:0] r_mem [FDEPTH];
    logic [C_PW-1:0] r_wr_ptr;
    logic [C_PW-1:0] r_rd_ptr;
    logic [C_LW-1:0] r_level;
    logic            r_ovf;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [C_EW-1:0] w_head;

    // Flags come only from the registered level, never from out_en.
    assign w_full  = (r_level == C_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & m_ready;
    assign w_push  = out_en & (~w_full | w_pop);
    assign w_drop  = out_en & ~w_push;

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= {addr_out, data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PW'(1);
            end
            r_level <= r_level + C_LW'(w_push) - C_LW'(w_pop);
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_head  = r_mem[r_rd_ptr];
    assign m_valid = ~w_empty;
    assign m_addr  = w_empty ? '0 : w_head[C_EW-1:NUBITS];
    assign m_data  = w_empty ? '0 : w_head[NUBITS-1:0];
    assign level   = r_level;
    assign full    = w_full;
    assign empty   = w_empty;
    assign ovf     = r_ovf;

`ifdef IO_OUT_FIFO_OVFCNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_out_fifo.sv
`default_nettype none
// ============================================================================
// tb_io_out_fifo : randomized and directed bench for io_out_fifo against a
//                  queue-based reference model.
// Revision       : 1.0
// ============================================================================
module tb_io_out_fifo;

    localparam int NUBITS = 32;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_en = 1'b0;
    logic [2:0]  addr_out = '0;
    logic [31:0] data_out = '0;
    logic        m_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        m_valid;
    logic [2:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        ovf;
`ifdef IO_OUT_FIFO_OVFCNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of {addr, data} plus the overflow state.
    logic [34:0] q[$];
    bit          m_ovf;
    int          m_cnt;

    always #5 clk = ~clk;

    io_out_fifo #(
        .NUBITS (NUBITS),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en),
        .addr_out (addr_out),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
`ifdef IO_OUT_FIFO_OVFCNT_EN
        .ovf_cnt  (ovf_cnt),
`endif
        .ovf_clr  (ovf_clr)
    );

    // Drives one cycle of inputs, then advances the model across the edge.
    task automatic cycle(input bit r, input bit en, input logic [2:0] a,
                         input logic [31:0] d, input bit rdy, input bit clr);
        bit pop, push, drop;
        rst = r; out_en = en; addr_out = a; data_out = d; m_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            pop  = (q.size() > 0) && rdy;
            push = en && ((q.size() < FDEPTH) || pop);
            drop = en && !push;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({a, d});
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (clr) m_cnt = drop ? 1 : 0;
            else if (drop && m_cnt < 255) m_cnt++;
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 3'd0, 32'd0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 3'd0, 32'd0, 0, 0);
        cycle(1, 0, 3'd0, 32'd0, 0, 0);
        idle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (m_data !== 32'd0 || m_addr !== 3'd0) begin errors++; $display("FAIL reset_head: got %0h/%0h expected 0/0", m_addr, m_data); end
    endtask

    task automatic test_single();
        cycle(0, 1, 3'd3, 32'h0000_00A5, 0, 0);
        checks++; if (m_valid !== 1'b1 || m_addr !== 3'd3 || m_data !== 32'hA5) begin
            errors++; $display("FAIL single_head: got v=%b a=%0d d=%0h expected 1/3/a5", m_valid, m_addr, m_data); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
        cycle(0, 0, 3'd0, 32'd0, 1, 0);
        checks++; if (level !== 4'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: got level=%0d v=%b expected 0/0", level, m_valid); end
        cycle(0, 0, 3'd0, 32'd0, 1, 0);
        checks++; if (level !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL ready_on_empty: got level=%0d empty=%b expected 0/1", level, empty); end
    endtask

    task automatic test_empty_push_ready();
        cycle(0, 1, 3'd5, 32'h1234_5678, 1, 0);
        checks++; if (level !== 4'd1 || m_data !== 32'h1234_5678 || m_addr !== 3'd5) begin
            errors++; $display("FAIL empty_push_ready: got level=%0d d=%0h expected 1/12345678", level, m_data); end
        cycle(0, 0, 3'd0, 32'd0, 1, 0);
    endtask

    task automatic test_order();
        for (int i = 0; i < FDEPTH; i++) cycle(0, 1, 3'(i), 32'(i + 1), 0, 0);
        checks++; if (full !== 1'b1 || level !== 4'd8) begin
            errors++; $display("FAIL order_full: got full=%b level=%0d expected 1/8", full, level); end
        idle();
        checks++; if (m_data !== 32'd1 || m_addr !== 3'd0) begin
            errors++; $display("FAIL order_hold: got %0h expected 1", m_data); end
        for (int i = 0; i < FDEPTH; i++) begin
            checks++; if (m_data !== 32'(i + 1) || m_addr !== 3'(i)) begin
                errors++; $display("FAIL order_drain[%0d]: got a=%0d d=%0h expected a=%0d d=%0h", i, m_addr, m_data, i, i + 1); end
            cycle(0, 0, 3'd0, 32'd0, 1, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < FDEPTH; i++) cycle(0, 1, 3'(i), 32'h10 + 32'(i), 0, 0);
        cycle(0, 1, 3'd7, 32'h99, 0, 0);
        checks++; if (ovf !== 1'b1 || level !== 4'd8) begin
            errors++; $display("FAIL ovf_drop: got ovf=%b level=%0d expected 1/8", ovf, level); end
`ifdef IO_OUT_FIFO_OVFCNT_EN
        checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt_drop: got %0d expected 1", ovf_cnt); end
`endif
        cycle(0, 0, 3'd0, 32'd0, 0, 1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
`ifdef IO_OUT_FIFO_OVFCNT_EN
        checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_cnt_clear: got %0d expected 0", ovf_cnt); end
`endif
        cycle(0, 1, 3'd1, 32'h98, 0, 1);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf); end
`ifdef IO_OUT_FIFO_OVFCNT_EN
        checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt_clr_drop: got %0d expected 1", ovf_cnt); end
        for (int i = 0; i < 260; i++) cycle(0, 1, 3'd0, 32'h97, 0, 0);
        checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_cnt_sat: got %0d expected 255", ovf_cnt); end
`endif
        cycle(0, 0, 3'd0, 32'd0, 0, 1);
        for (int i = 0; i < FDEPTH; i++) begin
            checks++; if (m_data !== 32'h10 + 32'(i)) begin
                errors++; $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, m_data, 32'h10 + 32'(i)); end
            cycle(0, 0, 3'd0, 32'd0, 1, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < FDEPTH; i++) cycle(0, 1, 3'(i), 32'h20 + 32'(i), 0, 0);
        cycle(0, 1, 3'd6, 32'h77, 1, 0);
        checks++; if (ovf !== 1'b0 || level !== 4'd8) begin
            errors++; $display("FAIL fullpp: got ovf=%b level=%0d expected 0/8", ovf, level); end
        for (int i = 1; i < FDEPTH; i++) begin
            checks++; if (m_data !== 32'h20 + 32'(i)) begin
                errors++; $display("FAIL fullpp_drain[%0d]: got %0h expected %0h", i, m_data, 32'h20 + 32'(i)); end
            cycle(0, 0, 3'd0, 32'd0, 1, 0);
        end
        checks++; if (m_data !== 32'h77 || m_addr !== 3'd6 || level !== 4'd1) begin
            errors++; $display("FAIL fullpp_last: got a=%0d d=%0h level=%0d expected 6/77/1", m_addr, m_data, level); end
        cycle(0, 0, 3'd0, 32'd0, 1, 0);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) cycle(0, 1, 3'(i), 32'h50 + 32'(i), 0, 0);
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level: got %0d expected 5", level); end
        cycle(1, 1, 3'd2, 32'h66, 1, 0);
        checks++; if (level !== 4'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got level=%0d v=%b expected 0/0", level, m_valid); end
        cycle(0, 1, 3'd4, 32'h42, 0, 0);
        checks++; if (m_data !== 32'h42 || level !== 4'd1) begin
            errors++; $display("FAIL mid_first: got d=%0h level=%0d expected 42/1", m_data, level); end
        cycle(0, 0, 3'd0, 32'd0, 1, 0);
    endtask

    task automatic test_random();
        logic [34:0] head;
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 3'($urandom),
                  $urandom, ($urandom_range(0, 2) == 0) || (n > 1500 && $urandom_range(0, 1) == 1),
                  ($urandom_range(0, 29) == 0));
            head = (q.size() > 0) ? q[0] : 35'd0;
            checks++; if (m_valid !== (q.size() > 0) || m_addr !== head[34:32] || m_data !== head[31:0]) begin
                errors++; $display("FAIL rand_head[%0d]: got v=%b a=%0d d=%0h expected v=%b a=%0d d=%0h",
                                   n, m_valid, m_addr, m_data, q.size() > 0, head[34:32], head[31:0]); end
            checks++; if (level !== 4'(q.size()) || full !== (q.size() == FDEPTH) || empty !== (q.size() == 0)) begin
                errors++; $display("FAIL rand_level[%0d]: got level=%0d full=%b empty=%b expected level=%0d",
                                   n, level, full, empty, q.size()); end
            checks++; if (ovf !== m_ovf) begin
                errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, ovf, m_ovf); end
`ifdef IO_OUT_FIFO_OVFCNT_EN
            checks++; if (ovf_cnt !== 8'(m_cnt)) begin
                errors++; $display("FAIL rand_ovf_cnt[%0d]: got %0d expected %0d", n, ovf_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_push_ready();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
